bus_demux2_resp: RTL and testbench
==================================

Name: bus_demux2_resp

Overview:
- Responder-side steering unit for the shared address/data bus; the return-direction counterpart to the 2:1 bus selectors.
- Accepts one request from a single master and decodes one address bit to pick one of two slave ports.
- Launches a registered request to that slave, waits for its acknowledge, and returns read data and acknowledge to the master.
- Sits between the CPU-side bus and two target regions (e.g. memory and I/O); one outstanding transaction at a time.

Parameters:
- ADDRESS_BUS_WIDTH, 16, address width; value taken from the shared params include.
- DATA_BUS_WIDTH, 16, data width; value taken from the shared params include.
- SEL_BIT, ADDRESS_BUS_WIDTH-1, address bit index selecting slave (0 -> s0, 1 -> s1).
- TIMEOUT_CYCLES, 15, max wait cycles in ACCESS before error completion; only used with TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_req  input  1  master request; sampled only in IDLE.
- m_we  input  1  master write enable (1 = write, 0 = read).
- m_addr  input  ADDRESS_BUS_WIDTH  master address.
- m_wdata  input  DATA_BUS_WIDTH  master write data.
- m_ack  output  1  one-cycle completion pulse to master.
- m_rdata  output  DATA_BUS_WIDTH  read data returned to master.
- m_err  output  1  error flag; valid with m_ack.
- busy  output  1  high while a transaction is in flight (ACCESS or DONE).
- s0_req, s1_req  output  1  per-slave request; registered, level-held.
- s0_we, s1_we  output  1  per-slave write enable.
- s0_addr, s1_addr  output  ADDRESS_BUS_WIDTH  per-slave address; full address passed through, not stripped.
- s0_wdata, s1_wdata  output  DATA_BUS_WIDTH  per-slave write data.
- s0_ack, s1_ack  input  1  per-slave acknowledge.
- s0_rdata, s1_rdata  input  DATA_BUS_WIDTH  per-slave read data; valid with its ack.

Behaviour:
- Reset: rst_n low forces IDLE immediately, without waiting for clk.
  - All outputs go to 0: m_ack, m_err, m_rdata, busy, sX_req, sX_we, sX_addr, sX_wdata.
  - Internal target and timeout counter also clear.
- Reset mid-transaction: the transaction is abandoned. No m_ack is issued, and the slave request drops asynchronously.
- States are IDLE, ACCESS, DONE. Encoding is free.
- IDLE:
  - On a clk edge with m_req=1: latch m_addr, m_we, m_wdata; set target=m_addr[SEL_BIT]; go to ACCESS.
  - Only the target slave's req/we/addr/wdata are driven. The non-target slave's outputs are held at 0.
- ACCESS:
  - sTarget_req=1 and busy=1.
  - On an edge with sTarget_ack=1: capture sTarget_rdata into m_rdata if read (m_rdata unchanged on write), drop sTarget_req, go to DONE.
  - Ack from the non-target slave is ignored.
- DONE: m_ack=1 for exactly one cycle, m_err=0, busy=1; go to IDLE.
- Back in IDLE:
  - busy=0.
  - If m_req is still high, a new transaction is accepted at the next edge. Minimum back-to-back spacing is 3 cycles.
- Latency (slave acks in its first request cycle): m_req sampled at edge N -> sX_req high after N -> ack sampled at N+1 -> m_ack high in cycle after N+2 edge... precisely, m_ack is high between edges N+2 and N+3 (2-cycle minimum request-to-ack).
- Master fields are latched, so master inputs may change freely after acceptance.
- m_req during ACCESS/DONE is ignored, not queued.
- sX_ack/m_req while in IDLE with no request pending has no effect. sX_ack in DONE is ignored.
- m_rdata holds its value until the next successful read completion.
- Target address/data outputs are stable for the entire ACCESS state.

Optional Feature:
- TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without target ack.
  - When the count reaches TIMEOUT_CYCLES: drop sTarget_req, go to DONE, and drive m_ack=1 with m_err=1. m_rdata is unchanged.
  - An ack arriving on the same edge the count reaches TIMEOUT_CYCLES wins: normal completion, m_err=0.
- TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, m_err tied 0, TIMEOUT_CYCLES unused.

Test Plan:
- Read s0: m_addr=0x1234, m_we=0, s0 acks next cycle with rdata=0xBEEF -> s0_req high 1 cycle, s0_addr=0x1234, s1_req stays 0, m_ack pulse 2 cycles after acceptance, m_rdata=0xBEEF, m_err=0.
- Write s1 with 3 wait cycles: m_addr=0x8010, m_wdata=0x55AA, m_we=1, s1 ack after 3 cycles -> s1_req held 4 cycles with s1_wdata=0x55AA; m_ack single pulse; m_rdata keeps prior 0xBEEF.
- Wrong-slave ack: target s0, s1_ack pulsed during ACCESS -> ignored, stays in ACCESS; completes only on s0_ack; m_req pulses during busy produce no extra transactions.
- Async reset mid-ACCESS: assert rst_n=0 between edges -> s0_req, busy, and all outputs 0 without clk edge; after release, no m_ack; new read completes normally.
- TIMEOUT_EN, TIMEOUT_CYCLES=15: target s1 never acks -> s1_req drops after 15 ACCESS cycles, m_ack=1 with m_err=1, m_rdata unchanged; repeat with ack on cycle 15 edge -> m_err=0, data returned.

Source files
------------

// File: rtl/bus_demux2_resp.sv
// Steers one master bus request to slave s0 or s1 by address bit SEL_BIT and returns rdata/ack.
// Latency: request accepted at edge N, slave req high from N, m_ack high N+2..N+3 at the earliest.
// Backpressure: one transaction in flight; m_req is ignored while busy and waits on the target ack.
// Optional: define TIMEOUT_EN to end a stalled access with m_err after TIMEOUT_CYCLES cycles.
module bus_demux2_resp #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int SEL_BIT           = ADDRESS_BUS_WIDTH - 1,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // master side
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] m_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    m_wdata,
    output logic                         m_ack,
    output logic [DATA_BUS_WIDTH-1:0]    m_rdata,
    output logic                         m_err,
    output logic                         busy,
    // slave 0
    output logic                         s0_req,
    output logic                         s0_we,
    output logic [ADDRESS_BUS_WIDTH-1:0] s0_addr,
    output logic [DATA_BUS_WIDTH-1:0]    s0_wdata,
    input  logic                         s0_ack,
    input  logic [DATA_BUS_WIDTH-1:0]    s0_rdata,
    // slave 1
    output logic                         s1_req,
    output logic                         s1_we,
    output logic [ADDRESS_BUS_WIDTH-1:0] s1_addr,
    output logic [DATA_BUS_WIDTH-1:0]    s1_wdata,
    input  logic                         s1_ack,
    input  logic [DATA_BUS_WIDTH-1:0]    s1_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                         r_state;
    logic                           r_target;
    logic                           r_we;
    logic                           r_ack;
    logic                           r_busy;
    logic [DATA_BUS_WIDTH-1:0]      r_rdata;
    logic                           r_s0_req;
    logic                           r_s0_we;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_s0_addr;
    logic [DATA_BUS_WIDTH-1:0]      r_s0_wdata;
    logic                           r_s1_req;
    logic                           r_s1_we;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_s1_addr;
    logic [DATA_BUS_WIDTH-1:0]      r_s1_wdata;

    logic                           w_tgt_ack;
    logic [DATA_BUS_WIDTH-1:0]      w_tgt_rdata;
    logic                           w_sel;

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_err_pend;
    logic                           r_err;
`endif

    // Only the selected slave's ack/rdata can complete an access; the other is ignored.
    assign w_tgt_ack   = r_target ? s1_ack   : s0_ack;
    assign w_tgt_rdata = r_target ? s1_rdata : s0_rdata;
    assign w_sel       = m_addr[SEL_BIT];

    // Transaction FSM with all master/slave outputs registered.
    // m_ack is launched on the edge leaving DONE, giving the 2-cycle minimum request-to-ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_target   <= 1'b0;
            r_we       <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= '0;
            r_s0_req   <= 1'b0;
            r_s0_we    <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_wdata <= '0;
            r_s1_req   <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_wdata <= '0;
`ifdef TIMEOUT_EN
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        r_target <= w_sel;
                        r_we     <= m_we;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ACCESS;
                        // Drive the chosen slave, hold the other at zero.
                        r_s0_req   <= !w_sel;
                        r_s0_we    <= !w_sel ? m_we    : 1'b0;
                        r_s0_addr  <= !w_sel ? m_addr  : '0;
                        r_s0_wdata <= !w_sel ? m_wdata : '0;
                        r_s1_req   <= w_sel;
                        r_s1_we    <= w_sel ? m_we    : 1'b0;
                        r_s1_addr  <= w_sel ? m_addr  : '0;
                        r_s1_wdata <= w_sel ? m_wdata : '0;
`ifdef TIMEOUT_EN
                        r_cnt      <= '0;
                        r_err_pend <= 1'b0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (w_tgt_ack) begin
                        if (!r_we) begin
                            r_rdata <= w_tgt_rdata;
                        end
                        r_s0_req <= 1'b0;
                        r_s1_req <= 1'b0;
                        r_state  <= ST_DONE;
`ifdef TIMEOUT_EN
                    // An ack on the same edge takes priority over the timeout.
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_s0_req   <= 1'b0;
                        r_s1_req   <= 1'b0;
                        r_err_pend <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                ST_DONE: begin
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef TIMEOUT_EN
                    r_err   <= r_err_pend;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack    = r_ack;
    assign m_rdata  = r_rdata;
    assign busy     = r_busy;
    assign s0_req   = r_s0_req;
    assign s0_we    = r_s0_we;
    assign s0_addr  = r_s0_addr;
    assign s0_wdata = r_s0_wdata;
    assign s1_req   = r_s1_req;
    assign s1_we    = r_s1_we;
    assign s1_addr  = r_s1_addr;
    assign s1_wdata = r_s1_wdata;

`ifdef TIMEOUT_EN
    assign m_err = r_err;
`else
    assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_demux2_resp.sv
// Randomized bench for bus_demux2_resp against a transaction-level reference model.
// Build with +define+TIMEOUT_EN to also exercise the timeout completion path.
module tb_bus_demux2_resp;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef TIMEOUT_EN
    localparam int TO_LAST = 14;   // last ACCESS cycle index before the 15-cycle timeout
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack, m_err, busy;
    logic [DW-1:0] m_rdata;
    logic          s0_req, s0_we, s1_req, s1_we;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [DW-1:0] s0_wdata, s1_wdata;
    logic          s0_ack, s1_ack;
    logic [DW-1:0] s0_rdata, s1_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_rdata;

    always #5 clk = ~clk;

    bus_demux2_resp dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err), .busy(busy),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_ack(s0_ack), .s0_rdata(s0_rdata),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_ack(s1_ack), .s1_rdata(s1_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  {30'd0, s1_req, s0_req}, 0);
        chk({tag, "_ack"},  {30'd0, m_err, m_ack}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"},   m_rdata, 0);
        chk({tag, "_s0"},   {s0_we, s0_addr, s0_wdata}, 0);
        chk({tag, "_s1"},   {s1_we, s1_addr, s1_wdata}, 0);
    endtask

    // Called at a negedge with the DUT idle. w = cycles the target waits before acking.
    task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int w, input bit noise);
        logic tgt;
        bit   to;
        int   last;
        logic t_req, o_req, t_we;
        logic [AW-1:0] t_addr, o_addr;
        logic [DW-1:0] t_wd, o_wd;
        tgt  = addr[AW-1];
        to   = 1'b0;
        last = w;
`ifdef TIMEOUT_EN
        if (w > TO_LAST) begin
            to   = 1'b1;
            last = TO_LAST;
        end
`endif
        if (!we && !to) exp_rdata = rd;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble master inputs: the DUT must have latched them.
        m_req = 1'b0; m_we = 1'($urandom); m_addr = AW'($urandom); m_wdata = DW'($urandom);
        for (int c = 0; c <= last + 2; c++) begin
            t_req  = tgt ? s1_req   : s0_req;   o_req  = tgt ? s0_req   : s1_req;
            t_we   = tgt ? s1_we    : s0_we;
            t_addr = tgt ? s1_addr  : s0_addr;  o_addr = tgt ? s0_addr  : s1_addr;
            t_wd   = tgt ? s1_wdata : s0_wdata; o_wd   = tgt ? s0_wdata : s1_wdata;
            chk("tgt_req", t_req, c <= last);
            chk("oth_req", o_req, 0);
            chk("oth_bus", {o_addr, o_wd}, 0);
            chk("busy", busy, c <= last + 1);
            chk("m_ack", m_ack, c == last + 2);
            if (c <= last) begin
                chk("tgt_addr", t_addr, addr);
                chk("tgt_we", t_we, we);
                chk("tgt_wdata", t_wd, wd);
            end
            if (c == last + 2) begin
                chk("m_err", m_err, to);
                chk("m_rdata", m_rdata, exp_rdata);
            end
            // Target acks in cycle w with valid data; otherwise rdata is garbage.
            s0_ack   = (!tgt && c == w && !to);
            s1_ack   = ( tgt && c == w && !to);
            s0_rdata = (!tgt && c == w) ? rd : DW'($urandom);
            s1_rdata = ( tgt && c == w) ? rd : DW'($urandom);
            if (noise) begin
                if (tgt) s0_ack = 1'($urandom);
                else     s1_ack = 1'($urandom);
                m_req = (c <= last + 1) ? 1'($urandom) : 1'b0;
            end
            @(negedge clk);
        end
        s0_ack = 1'b0; s1_ack = 1'b0; m_req = 1'b0;
        chk("ack_pulse", m_ack, 0);
        chk("idle_busy", busy, 0);
    endtask

    // Abandon an s0 read mid-ACCESS with an asynchronous reset.
    task automatic reset_mid_access();
        m_req = 1'b1; m_we = 1'b0; m_addr = 16'h0040; m_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", s0_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_ack", m_ack, 0);
            chk("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s0_ack = 1'b0; s1_ack = 1'b0; s0_rdata = '0; s1_rdata = '0;
        exp_rdata = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(16'h1234, 1'b0, 16'h0000, 16'hBEEF, 0, 1'b0);
        run_txn(16'h8010, 1'b1, 16'h55AA, 16'h0BAD, 3, 1'b0);
        run_txn(16'h0042, 1'b0, 16'h0000, 16'hC0DE, 4, 1'b1);
        reset_mid_access();
        run_txn(16'h0100, 1'b0, 16'h0000, 16'hA5A5, 1, 1'b0);
`ifdef TIMEOUT_EN
        run_txn(16'h8000, 1'b0, 16'h0000, 16'h1111, 100, 1'b0);
        run_txn(16'h8002, 1'b0, 16'h0000, 16'h2222, TO_LAST, 1'b0);
`else
        run_txn(16'h8004, 1'b0, 16'h0000, 16'h3333, 20, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            run_txn(AW'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
                    $urandom_range(0, 6), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
